// File: rtl/reg_file_sb.sv
// -----------------------------------------------------------------------------
// reg_file_sb
//
// This block is a 32x32 register file with a per-register write scoreboard.
//
// Register file
//   - A3/WD3/WE3 is the writeback port.
//   - A1/A2 are the decode read ports (rs, rt). Reads are combinational.
//   - Register 0 always reads as zero. Writes and issues to it are ignored.
//
// Scoreboard
//   - Each register has one busy bit.
//   - The bit is set when an instruction with that destination is issued to a
//     multicycle unit.
//   - It is cleared when that register is written back.
//   - stall holds decode while a source operand it consumes is still busy.
//   - sb_err is sticky. It records an issue to a register that was already
//     busy and was not retired on the same edge.
//
// Optional feature (macro REGFILE_BYPASS_EN)
//   - Defined: a same-cycle writeback is forwarded onto RD1/RD2, and it
//     removes the busy condition for that port in the same cycle.
//   - Undefined: reads see stored registers only. A consumer waiting on a
//     writeback therefore stalls one extra cycle.
//
// Ports
//   clk       in   1         rising-edge clock
//   rst_n     in   1         asynchronous active-low reset
//   A1, A2    in   ADDR_W    read addresses (rs, rt)
//   use1/2    in   1         decode consumes read port 1/2 this cycle
//   RD1, RD2  out  DATA_W    read data
//   WE3       in   1         writeback enable
//   A3        in   ADDR_W    writeback address
//   WD3       in   DATA_W    writeback data
//   issue_en  in   1         instruction with a destination is issued
//   issue_A3  in   ADDR_W    issued destination address
//   stall     out  1         a consumed source is pending; hold decode
//   pend_cnt  out  ADDR_W+1  number of busy registers (registered)
//   sb_err    out  1         sticky double-issue error
// -----------------------------------------------------------------------------
module reg_file_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    input  logic              use1,
    input  logic              use2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    input  logic              WE3,
    input  logic [ADDR_W-1:0] A3,
    input  logic [DATA_W-1:0] WD3,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_A3,
    output logic              stall,
    output logic [ADDR_W:0]   pend_cnt,
    output logic              sb_err
);

    localparam int NREG  = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    // Number of set bits in a scoreboard vector.
    function automatic logic [CNT_W-1:0] popCount(input logic [NREG-1:0] bits);
        logic [CNT_W-1:0] cnt;
        cnt = {CNT_W{1'b0}};
        for (int i = 0; i < NREG; i++) begin
            cnt = cnt + CNT_W'(bits[i]);
        end
        return cnt;
    endfunction

    logic [DATA_W-1:0] regs_r [NREG];
    logic [NREG-1:0]   sb_r;
    logic [NREG-1:0]   sbNext_s;
    logic              sbErr_r;
    logic [CNT_W-1:0]  pendCnt_r;

    logic              fwd1_s;
    logic              fwd2_s;
    logic              busy1_s;
    logic              busy2_s;
    logic              stall_s;
    logic              wbClr_s;
    logic              issueAcc_s;
    logic              errHit_s;
    logic [DATA_W-1:0] rd1_s;
    logic [DATA_W-1:0] rd2_s;

`ifdef REGFILE_BYPASS_EN
    // The writeback in flight this cycle is forwarded onto a matching read port.
    assign fwd1_s = WE3 && (A3 == A1) && (A1 != ADDR_ZERO);
    assign fwd2_s = WE3 && (A3 == A2) && (A2 != ADDR_ZERO);
`else
    assign fwd1_s = 1'b0;
    assign fwd2_s = 1'b0;
`endif

    // Read data and per-port busy. A forwarded port is never considered busy.
    always_comb begin
        rd1_s   = (A1 == ADDR_ZERO) ? DATA_ZERO : (fwd1_s ? WD3 : regs_r[A1]);
        rd2_s   = (A2 == ADDR_ZERO) ? DATA_ZERO : (fwd2_s ? WD3 : regs_r[A2]);
        busy1_s = (A1 != ADDR_ZERO) && sb_r[A1] && !fwd1_s;
        busy2_s = (A2 != ADDR_ZERO) && sb_r[A2] && !fwd2_s;
        stall_s = (use1 && busy1_s) || (use2 && busy2_s);
    end

    assign wbClr_s    = WE3 && (A3 != ADDR_ZERO);
    // An issue is accepted only while decode is not held.
    assign issueAcc_s = issue_en && !stall_s && (issue_A3 != ADDR_ZERO);
    // A double issue is forgiven when the old producer retires on the same edge.
    assign errHit_s   = issueAcc_s && sb_r[issue_A3]
                        && !(wbClr_s && (A3 == issue_A3));

    // Next scoreboard value. An issue has priority over a writeback to the same register.
    always_comb begin
        sbNext_s = sb_r;
        for (int i = 0; i < NREG; i++) begin
            if (issueAcc_s && (issue_A3 == ADDR_W'(i))) begin
                sbNext_s[i] = 1'b1;
            end else if (wbClr_s && (A3 == ADDR_W'(i))) begin
                sbNext_s[i] = 1'b0;
            end else begin
                sbNext_s[i] = sb_r[i];
            end
        end
        sbNext_s[0] = 1'b0;
    end

    // Register storage. Register 0 is never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= DATA_ZERO;
            end
        end else if (wbClr_s) begin
            regs_r[A3] <= WD3;
        end
    end

    // Scoreboard bits, the sticky error flag and the registered busy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_r      <= {NREG{1'b0}};
            sbErr_r   <= 1'b0;
            pendCnt_r <= {CNT_W{1'b0}};
        end else begin
            sb_r      <= sbNext_s;
            sbErr_r   <= sbErr_r || errHit_s;
            pendCnt_r <= popCount(sbNext_s);
        end
    end

    assign RD1      = rd1_s;
    assign RD2      = rd2_s;
    assign stall    = stall_s;
    assign pend_cnt = pendCnt_r;
    assign sb_err   = sbErr_r;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb.
// Each scenario task drives stimulus and queues the values the outputs should
// show. Each expectation is snapshotted at the sample point, and the task
// compares its own queue at the end.
module tb_reg_file_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam int K_RD1   = 0;
    localparam int K_RD2   = 1;
    localparam int K_STALL = 2;
    localparam int K_PEND  = 3;
    localparam int K_ERR   = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] A1, A2, A3, issue_A3;
    logic              use1, use2, WE3, issue_en;
    logic [DATA_W-1:0] WD3, RD1, RD2;
    logic              stall, sb_err;
    logic [ADDR_W:0]   pend_cnt;

    typedef struct {
        int          kind;
        logic [31:0] want;
        logic [31:0] got;
        bit          taken;
        string       name;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    reg_file_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .A1(A1), .A2(A2), .use1(use1), .use2(use2),
        .RD1(RD1), .RD2(RD2),
        .WE3(WE3), .A3(A3), .WD3(WD3),
        .issue_en(issue_en), .issue_A3(issue_A3),
        .stall(stall), .pend_cnt(pend_cnt), .sb_err(sb_err)
    );

    function automatic logic [31:0] observe(int kind);
        case (kind)
            K_RD1:   return RD1;
            K_RD2:   return RD2;
            K_STALL: return {31'd0, stall};
            K_PEND:  return {26'd0, pend_cnt};
            default: return {31'd0, sb_err};
        endcase
    endfunction

    task automatic push(input int kind, input logic [31:0] want, input string name);
        exp_t e;
        e.kind = kind; e.want = want; e.got = 32'd0; e.taken = 1'b0; e.name = name;
        q.push_back(e);
    endtask

    // Snapshot current DUT outputs into every expectation not yet sampled.
    task automatic capture();
        foreach (q[i]) begin
            if (!q[i].taken) begin
                q[i].got   = observe(q[i].kind);
                q[i].taken = 1'b1;
            end
        end
    endtask

    task automatic idle();
        WE3 = 1'b0; A3 = 5'd0; WD3 = 32'd0;
        issue_en = 1'b0; issue_A3 = 5'd0;
        use1 = 1'b0; use2 = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        capture();
    endtask

    task automatic test_reset();
        idle(); A1 = 5'd0; A2 = 5'd5; rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        push(K_RD1, 32'd0, "rst_rd1"); push(K_RD2, 32'd0, "rst_rd2");
        push(K_STALL, 32'd0, "rst_stall"); push(K_PEND, 32'd0, "rst_pend");
        push(K_ERR, 32'd0, "rst_err");
        sample();
        rst_n = 1'b1;
        while (q.size() > 0) begin
            exp_t e = q.pop_front();
            total++;
            if (e.got !== e.want) begin
                bad++; $display("FAIL %s: got %h want %h", e.name, e.got, e.want);
            end
        end
    endtask

    task automatic test_write_read();
        next_cycle(); idle(); WE3 = 1'b1; A3 = 5'd5; WD3 = 32'hDEADBEEF; A1 = 5'd5; A2 = 5'd0;
`ifdef REGFILE_BYPASS_EN
        push(K_RD1, 32'hDEADBEEF, "wr_same_cycle_rd1");
`else
        push(K_RD1, 32'd0, "wr_same_cycle_rd1");
`endif
        sample();
        next_cycle(); idle(); A1 = 5'd5; A2 = 5'd0; WE3 = 1'b1; A3 = 5'd0; WD3 = 32'd1;
        push(K_RD1, 32'hDEADBEEF, "wr_rd1_next"); push(K_RD2, 32'd0, "wr0_rd2_same");
        sample();
        next_cycle(); idle(); A2 = 5'd0; A1 = 5'd6; WE3 = 1'b1; A3 = 5'd6; WD3 = 32'h12345678;
        push(K_RD2, 32'd0, "wr0_rd2_next"); push(K_PEND, 32'd0, "wr_pend0");
        sample();
        next_cycle(); idle(); A1 = 5'd6; A2 = 5'd5;
        push(K_RD1, 32'h12345678, "wr_rd1_r6"); push(K_RD2, 32'hDEADBEEF, "wr_rd2_r5");
        sample();
        while (q.size() > 0) begin
            exp_t e = q.pop_front();
            total++;
            if (e.got !== e.want) begin
                bad++; $display("FAIL %s: got %h want %h", e.name, e.got, e.want);
            end
        end
    endtask

    task automatic test_stall();
        next_cycle(); idle(); issue_en = 1'b1; issue_A3 = 5'd8; A1 = 5'd8; A2 = 5'd5;
        push(K_STALL, 32'd0, "st_issue_cycle"); push(K_PEND, 32'd0, "st_pend_before");
        sample();
        next_cycle(); idle(); A1 = 5'd8; A2 = 5'd5; use1 = 1'b1;
        push(K_STALL, 32'd1, "st_busy_rs"); push(K_PEND, 32'd1, "st_pend1");
        sample();
        next_cycle(); idle(); A1 = 5'd8; A2 = 5'd8; use2 = 1'b1;
        push(K_STALL, 32'd1, "st_busy_rt");
        sample();
        next_cycle(); idle(); A1 = 5'd8; A2 = 5'd8;
        push(K_STALL, 32'd0, "st_unused");
        sample();
        next_cycle(); idle(); A1 = 5'd8; A2 = 5'd5; use1 = 1'b1;
        WE3 = 1'b1; A3 = 5'd8; WD3 = 32'hCAFE0008;
`ifdef REGFILE_BYPASS_EN
        push(K_STALL, 32'd0, "st_wb_cycle"); push(K_RD1, 32'hCAFE0008, "st_wb_rd1");
`else
        push(K_STALL, 32'd1, "st_wb_cycle"); push(K_RD1, 32'd0, "st_wb_rd1");
`endif
        push(K_PEND, 32'd1, "st_wb_pend");
        sample();
        next_cycle(); idle(); A1 = 5'd8; use1 = 1'b1;
        push(K_STALL, 32'd0, "st_after_wb"); push(K_RD1, 32'hCAFE0008, "st_after_rd1");
        push(K_PEND, 32'd0, "st_after_pend");
        sample();
        while (q.size() > 0) begin
            exp_t e = q.pop_front();
            total++;
            if (e.got !== e.want) begin
                bad++; $display("FAIL %s: got %h want %h", e.name, e.got, e.want);
            end
        end
    endtask

    task automatic test_sb_err();
        next_cycle(); idle(); issue_en = 1'b1; issue_A3 = 5'd10; A1 = 5'd0; A2 = 5'd0;
        sample();
        next_cycle(); idle(); issue_en = 1'b1; issue_A3 = 5'd10; WE3 = 1'b1; A3 = 5'd10; WD3 = 32'hA;
        push(K_PEND, 32'd1, "er_pend_first");
        sample();
        next_cycle(); idle(); A1 = 5'd10; use1 = 1'b1;
        push(K_ERR, 32'd0, "er_no_set_wb_same_edge"); push(K_PEND, 32'd1, "er_set_wins_pend");
        push(K_STALL, 32'd1, "er_set_wins_busy");
        sample();
        next_cycle(); idle(); issue_en = 1'b1; issue_A3 = 5'd10;
        push(K_ERR, 32'd0, "er_before_double");
        sample();
        next_cycle(); idle();
        push(K_ERR, 32'd1, "er_set"); push(K_PEND, 32'd1, "er_pend_single_bit");
        sample();
        next_cycle(); idle(); issue_en = 1'b1; issue_A3 = 5'd10; WE3 = 1'b1; A3 = 5'd10; WD3 = 32'hB;
        sample();
        next_cycle(); idle(); A1 = 5'd10; use1 = 1'b1;
        push(K_ERR, 32'd1, "er_sticky"); push(K_PEND, 32'd1, "er_pend_after_pair");
        push(K_STALL, 32'd1, "er_busy_after_pair");
        sample();
        next_cycle(); idle(); WE3 = 1'b1; A3 = 5'd10; WD3 = 32'hC;
        sample();
        next_cycle(); idle(); WE3 = 1'b1; A3 = 5'd13; WD3 = 32'h13;
        push(K_PEND, 32'd0, "er_cleared_pend"); push(K_ERR, 32'd1, "er_sticky2");
        sample();
        next_cycle(); idle(); A1 = 5'd13;
        push(K_PEND, 32'd0, "wb_nonbusy_pend"); push(K_RD1, 32'h13, "wb_nonbusy_rd");
        sample();
        rst_n = 1'b0;
        #1;
        push(K_ERR, 32'd0, "er_cleared_by_reset");
        capture();
        #1 rst_n = 1'b1;
        while (q.size() > 0) begin
            exp_t e = q.pop_front();
            total++;
            if (e.got !== e.want) begin
                bad++; $display("FAIL %s: got %h want %h", e.name, e.got, e.want);
            end
        end
    endtask

    task automatic test_issue_while_stall();
        next_cycle(); idle(); issue_en = 1'b1; issue_A3 = 5'd11; A1 = 5'd11; A2 = 5'd0;
        sample();
        next_cycle(); idle(); A1 = 5'd11; use1 = 1'b1; issue_en = 1'b1; issue_A3 = 5'd7;
        push(K_STALL, 32'd1, "iws_stall");
        sample();
        next_cycle(); idle(); A1 = 5'd11; use1 = 1'b1; issue_en = 1'b1; issue_A3 = 5'd11;
        push(K_PEND, 32'd1, "iws_pend_unchanged"); push(K_STALL, 32'd1, "iws_stall2");
        sample();
        next_cycle(); idle(); A2 = 5'd7; use2 = 1'b1; issue_en = 1'b1; issue_A3 = 5'd0;
        push(K_STALL, 32'd0, "iws_r7_not_busy"); push(K_ERR, 32'd0, "iws_no_err");
        push(K_PEND, 32'd1, "iws_pend_still1");
        sample();
        next_cycle(); idle(); WE3 = 1'b1; A3 = 5'd11; WD3 = 32'h11;
        push(K_PEND, 32'd1, "issue0_ignored");
        sample();
        next_cycle(); idle();
        push(K_PEND, 32'd0, "iws_drained");
        sample();
        while (q.size() > 0) begin
            exp_t e = q.pop_front();
            total++;
            if (e.got !== e.want) begin
                bad++; $display("FAIL %s: got %h want %h", e.name, e.got, e.want);
            end
        end
    endtask

    task automatic test_reset_mid();
        next_cycle(); idle(); issue_en = 1'b1; issue_A3 = 5'd3;
        WE3 = 1'b1; A3 = 5'd12; WD3 = 32'hABCD1234;
        sample();
        next_cycle(); idle(); issue_en = 1'b1; issue_A3 = 5'd4;
        sample();
        next_cycle(); idle(); A1 = 5'd12; A2 = 5'd3; use2 = 1'b1;
        push(K_RD1, 32'hABCD1234, "rm_rd1_before"); push(K_PEND, 32'd2, "rm_pend2");
        push(K_STALL, 32'd1, "rm_stall_before");
        sample();
        #1 rst_n = 1'b0;
        #1;
        push(K_RD1, 32'd0, "rm_regs_cleared"); push(K_PEND, 32'd0, "rm_pend_cleared");
        push(K_STALL, 32'd0, "rm_stall_cleared"); push(K_ERR, 32'd0, "rm_err_clear");
        capture();
        #1 rst_n = 1'b1;
        next_cycle(); idle(); A1 = 5'd12; A2 = 5'd4; use2 = 1'b1;
        push(K_RD1, 32'd0, "rm_rd1_after"); push(K_PEND, 32'd0, "rm_pend_after");
        push(K_STALL, 32'd0, "rm_stall_after");
        sample();
        while (q.size() > 0) begin
            exp_t e = q.pop_front();
            total++;
            if (e.got !== e.want) begin
                bad++; $display("FAIL %s: got %h want %h", e.name, e.got, e.want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_stall();
        test_sb_err();
        test_issue_while_stall();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
